// File: rtl/komandara_k10_pkg.sv
// Shared types and constants for the K10 fetch path.
package komandara_k10_pkg;

   localparam int         FETCH_DEPTH_DEFAULT = 2;
   localparam logic [1:0] RVC_OPC_32          = 2'b11;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } fetch_word_t;

   // A 16-bit parcel starts a compressed instruction unless its opcode
   // field carries the 32-bit marker.
   function automatic logic is_rvc(input logic [1:0] opc);
      return opc != RVC_OPC_32;
   endfunction

endpackage

// File: rtl/k10_fetch_fifo.sv
// Small circular buffer of fetched words. Exposes the head and the entry
// behind it so the aligner can look across a word boundary.
module k10_fetch_fifo
   import komandara_k10_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH_DEFAULT,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  fetch_word_t      i_push_word,
   input  logic             i_pop,
   output fetch_word_t      o_head,
   output fetch_word_t      o_head1,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_word_t      mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= ptr_inc(wr_ptr);
         if (i_pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge i_clk) begin
      if (i_push && !i_flush) mem[wr_ptr] <= i_push_word;
   end

   assign o_head  = mem[rd_ptr];
   assign o_head1 = mem[ptr_inc(rd_ptr)];
   assign o_count = count;

endmodule

// File: rtl/k10_fetch_align.sv
// IF-stage fetch unit and 16/32-bit instruction aligner.
// Compressed-instruction support is built only when K10_FETCH_RVC_EN is
// defined; without it every instruction is a full aligned word.
module k10_fetch_align
   import komandara_k10_pkg::*;
#(
   parameter int          DEPTH     = FETCH_DEPTH_DEFAULT,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_req_valid,
   output logic [31:0] o_req_addr,
   input  logic        i_req_ready,
   input  logic        i_rsp_valid,
   input  logic [31:0] i_rsp_data,
   input  logic        i_rsp_err,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instr,
   output logic        o_is_compressed,
   output logic [31:0] o_pc,
   output logic        o_err
);

   localparam int CNT_W  = $clog2(DEPTH + 1);
   // Stale responses can pile up over back-to-back redirects; this is wide
   // enough for any realistic bus depth.
   localparam int DISC_W = 8;

`ifdef K10_FETCH_RVC_EN
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif

   logic [31:0]       fetch_addr;
   logic [31:0]       pc;
   logic [CNT_W-1:0]  outstanding;
   logic [CNT_W-1:0]  buf_count;
   logic [DISC_W-1:0] discard;
   logic [CNT_W:0]    in_use;

   fetch_word_t rsp_word;
   fetch_word_t w0;
   fetch_word_t w1;

   logic        req_fire;
   logic        rsp_keep;
   logic        rsp_drop;
   logic        push;
   logic        pop;
   logic        fire;

   logic        beat_valid;
   logic        beat_pop;
   logic        beat_step4;
   logic        beat_comp;
   logic        beat_err;
   logic [31:0] beat_instr;

   assign in_use      = {1'b0, outstanding} + {1'b0, buf_count};
   assign o_req_valid = i_rst_n && !i_redirect && (in_use < (CNT_W+1)'(DEPTH));
   assign o_req_addr  = fetch_addr;
   assign req_fire    = o_req_valid && i_req_ready;

   // The first 'discard' responses belong to requests made before a redirect.
   assign rsp_drop = i_rsp_valid && (discard != '0);
   assign rsp_keep = i_rsp_valid && (discard == '0);
   assign push     = rsp_keep && !i_redirect;
   assign rsp_word = '{data: i_rsp_data, err: i_rsp_err};

   assign fire = o_valid && i_ready && !i_redirect;
   assign pop  = fire && beat_pop;

   k10_fetch_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_redirect),
      .i_push      (push),
      .i_push_word (rsp_word),
      .i_pop       (pop),
      .o_head      (w0),
      .o_head1     (w1),
      .o_count     (buf_count)
   );

`ifdef K10_FETCH_RVC_EN
   // pc[1] is the halfword offset into the head word. A faulting head word
   // produces a word-sized fault beat without waiting for the next word.
   always_comb begin
      beat_valid = 1'b0;
      beat_pop   = 1'b0;
      beat_step4 = 1'b1;
      beat_comp  = 1'b0;
      beat_err   = 1'b0;
      beat_instr = '0;
      if (buf_count != '0) begin
         if (w0.err) begin
            beat_valid = 1'b1;
            beat_pop   = 1'b1;
            beat_err   = 1'b1;
         end else if (!pc[1]) begin
            beat_valid = 1'b1;
            if (is_rvc(w0.data[1:0])) begin
               beat_comp  = 1'b1;
               beat_step4 = 1'b0;
               beat_instr = {16'h0000, w0.data[15:0]};
            end else begin
               beat_pop   = 1'b1;
               beat_instr = w0.data;
            end
         end else if (is_rvc(w0.data[17:16])) begin
            beat_valid = 1'b1;
            beat_pop   = 1'b1;
            beat_comp  = 1'b1;
            beat_step4 = 1'b0;
            beat_instr = {16'h0000, w0.data[31:16]};
         end else begin
            // Straddling instruction: upper half of W0 plus lower half of W1.
            beat_valid = (buf_count > CNT_W'(1));
            beat_pop   = 1'b1;
            beat_err   = w1.err;
            beat_instr = w1.err ? '0 : {w1.data[15:0], w0.data[31:16]};
         end
      end
   end

   logic unused_w1_hi;
   assign unused_w1_hi = ^w1.data[31:16];
`else
   // Word-only fetch: every head word is one instruction.
   always_comb begin
      beat_valid = (buf_count != '0);
      beat_pop   = 1'b1;
      beat_step4 = 1'b1;
      beat_comp  = 1'b0;
      beat_err   = w0.err;
      beat_instr = w0.err ? '0 : w0.data;
   end

   logic unused_w1;
   assign unused_w1 = ^w1;
`endif

   assign o_valid         = beat_valid;
   assign o_instr         = beat_valid ? beat_instr : '0;
   assign o_is_compressed = beat_valid & beat_comp;
   assign o_err           = beat_valid & beat_err;
   assign o_pc            = pc;

   // Fetch address, PC, and in-flight accounting; redirect overrides all.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fetch_addr  <= {BOOT_ADDR[31:2], 2'b00};
         pc          <= BOOT_ADDR & PC_MASK;
         outstanding <= '0;
         discard     <= '0;
      end else if (i_redirect) begin
         fetch_addr  <= {i_redirect_pc[31:2], 2'b00};
         pc          <= i_redirect_pc & PC_MASK;
         outstanding <= '0;
         discard     <= discard + DISC_W'(outstanding)
                        - DISC_W'(i_rsp_valid && ((discard != '0) || (outstanding != '0)));
      end else begin
         if (req_fire) fetch_addr <= fetch_addr + 32'd4;
         outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_keep);
         if (rsp_drop) discard <= discard - DISC_W'(1);
         if (fire) pc <= pc + (beat_step4 ? 32'd4 : 32'd2);
      end
   end

endmodule

// File: tb/tb_k10_fetch_align.sv
// Self-checking bench for k10_fetch_align. The reference model works at the
// instruction-stream level: from the expected PC and a memory image it
// derives the next instruction, and it tracks fresh vs. stale bus traffic.
module tb_k10_fetch_align;

   localparam int          DEPTH = 2;
   localparam logic [31:0] BOOT  = 32'h0000_0100;
`ifdef K10_FETCH_RVC_EN
   localparam bit RVC = 1'b1;
`else
   localparam bit RVC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_rst_n, i_redirect, i_req_ready, i_rsp_valid, i_rsp_err, i_ready;
   logic [31:0] i_redirect_pc, i_rsp_data;
   logic        o_req_valid, o_valid, o_is_compressed, o_err;
   logic [31:0] o_req_addr, o_instr, o_pc;

   always #5 clk = ~clk;

   k10_fetch_align #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
      .i_clk           (clk),
      .i_rst_n         (i_rst_n),
      .i_redirect      (i_redirect),
      .i_redirect_pc   (i_redirect_pc),
      .o_req_valid     (o_req_valid),
      .o_req_addr      (o_req_addr),
      .i_req_ready     (i_req_ready),
      .i_rsp_valid     (i_rsp_valid),
      .i_rsp_data      (i_rsp_data),
      .i_rsp_err       (i_rsp_err),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_instr         (o_instr),
      .o_is_compressed (o_is_compressed),
      .o_pc            (o_pc),
      .o_err           (o_err)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        stale;
   } mreq_t;

   int          n_asserts = 0;
   int          n_fail    = 0;
   logic [31:0] mem_img [logic [31:0]];
   bit          err_img [logic [31:0]];
   mreq_t       mq [$];
   logic [31:0] pc_exp, base;
   int unsigned acc_cnt, fresh_cnt, last_in_flight;
   logic        last_valid;
   int          beats;
   bit          saw_err108;
   int          rdy_pct = 100, rsp_pct = 100, req_rdy_pct = 100;
   bit          rsp_en = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pc_mask(input logic [31:0] a);
      return RVC ? (a & 32'hFFFF_FFFE) : (a & 32'hFFFF_FFFC);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] h;
      if (mem_img.exists(a)) return mem_img[a];
      h = a * 32'h9E37_79B1;
      h = h ^ (h >> 15);
      return h;
   endfunction

   function automatic logic mem_er(input logic [31:0] a);
      logic [31:0] h;
      if (err_img.exists(a)) return err_img[a];
      h = (a ^ 32'h5BD1_E995) * 32'h2545_F491;
      return (a >= 32'h1000) && (h[27:24] == 4'h0);
   endfunction

   // Next instruction at pc; 'need' is how many words beyond the one
   // holding pc must have arrived before it can be presented.
   task automatic model_beat(input logic [31:0] pc, output logic [31:0] instr,
                             output logic comp, output logic err,
                             output logic [31:0] len, output int need);
      logic [31:0] wa, w0, w1;
      logic [15:0] half;
      logic        e0, e1;
      wa = {pc[31:2], 2'b00};
      w0 = mem_rd(wa);
      e0 = mem_er(wa);
      instr = '0; comp = 1'b0; err = 1'b0; len = 32'd4; need = 0;
      if (e0) err = 1'b1;
      else if (!RVC) instr = w0;
      else begin
         half = pc[1] ? w0[31:16] : w0[15:0];
         if (half[1:0] != 2'b11) begin
            instr = {16'h0000, half}; comp = 1'b1; len = 32'd2;
         end else if (!pc[1]) begin
            instr = w0;
         end else begin
            need  = 1;
            w1    = mem_rd(wa + 32'd4);
            e1    = mem_er(wa + 32'd4);
            err   = e1;
            instr = e1 ? '0 : {w1[15:0], half};
         end
      end
   endtask

   // One clock: drive at negedge, check 1 ns later, then advance the model.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit force_rsp);
      bit          give_rsp, fresh_rsp;
      mreq_t       r;
      logic [31:0] e_instr, e_len;
      logic        e_comp, e_err;
      int          need;
      int unsigned consumed, in_flight;
      @(negedge clk);
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_req_ready   = ($urandom_range(99) < req_rdy_pct);
      i_ready       = ($urandom_range(99) < rdy_pct);
      give_rsp  = (mq.size() > 0) && rsp_en && (force_rsp || ($urandom_range(99) < rsp_pct));
      fresh_rsp = 1'b0;
      if (give_rsp) begin
         r           = mq.pop_front();
         i_rsp_valid = 1'b1;
         i_rsp_data  = mem_rd(r.addr);
         i_rsp_err   = mem_er(r.addr);
         fresh_rsp   = !r.stale && !redir;
      end else begin
         i_rsp_valid = 1'b0;
         i_rsp_data  = $urandom;
         i_rsp_err   = 1'b0;
      end
      #1;
      consumed  = (({pc_exp[31:2], 2'b00}) - base) >> 2;
      in_flight = acc_cnt - consumed;
      chk("req_valid", o_req_valid, !redir && (in_flight < DEPTH));
      if (o_req_valid) chk("req_addr", o_req_addr, base + 32'(4 * acc_cnt));
      chk("pc", o_pc, pc_exp);
      model_beat(pc_exp, e_instr, e_comp, e_err, e_len, need);
      chk("valid_early", o_valid && !(fresh_cnt > consumed + need), 1'b0);
      if (o_valid) begin
         chk("instr", o_instr, e_instr);
         chk("compressed", o_is_compressed, e_comp);
         chk("err", o_err, e_err);
      end
      last_in_flight = in_flight;
      last_valid     = o_valid;
      if (redir) begin
         pc_exp    = pc_mask(rpc);
         base      = {rpc[31:2], 2'b00};
         acc_cnt   = 0;
         fresh_cnt = 0;
         foreach (mq[i]) mq[i].stale = 1'b1;
      end else begin
         if (o_req_valid && i_req_ready) begin
            mq.push_back('{addr: o_req_addr, stale: 1'b0});
            acc_cnt++;
         end
         if (fresh_rsp) fresh_cnt++;
         if (o_valid && i_ready) begin
            if (pc_exp == 32'h108 && o_err) saw_err108 = 1'b1;
            pc_exp = pc_exp + e_len;
            beats++;
         end
      end
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0; i_redirect = 1'b0; i_rsp_valid = 1'b0;
      i_ready = 1'b0; i_req_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", o_req_valid, 1'b0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_instr", o_instr, 32'h0);
      chk("rst_compressed", o_is_compressed, 1'b0);
      chk("rst_err", o_err, 1'b0);
      chk("rst_pc", o_pc, BOOT);
      mq.delete();
      pc_exp = pc_mask(BOOT); base = {BOOT[31:2], 2'b00};
      acc_cnt = 0; fresh_cnt = 0; saw_err108 = 1'b0;
      i_rst_n = 1'b1;
   endtask

   initial begin
      int b0;
      i_rst_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_req_ready = 1'b0;
      i_rsp_valid = 1'b0; i_rsp_data = '0; i_rsp_err = 1'b0; i_ready = 1'b0;
      beats = 0;
      for (int k = 0; k < 16; k++) mem_img[32'h100 + 32'(4 * k)] = {k[11:0], 20'h00513};
      mem_img[32'h300] = 32'h0001_4501;
      mem_img[32'h304] = 32'h0000_0013;
      mem_img[32'h200] = 32'h0513_0001;
      mem_img[32'h204] = 32'h0000_0000;
      err_img[32'h108] = 1'b1;

      // Boot fetch from BOOT with a zero-latency memory.
      do_reset();
      b0 = beats;
      repeat (20) step(1'b0, '0, 1'b0);
      chk("boot_beats", (beats - b0) >= 5, 1'b1);

      // Mixed compressed / 32-bit words.
      step(1'b1, 32'h300, 1'b0);
      repeat (12) step(1'b0, '0, 1'b0);

      // Straddling instruction at a halfword-offset target.
      step(1'b1, 32'h202, 1'b0);
      repeat (12) step(1'b0, '0, 1'b0);

      // Two requests outstanding, then redirect: stale words must be dropped.
      rsp_en = 1'b0;
      repeat (3) step(1'b0, '0, 1'b0);
      step(1'b1, 32'h400, 1'b0);
      rsp_en = 1'b1;
      b0 = beats;
      repeat (15) step(1'b0, '0, 1'b0);
      chk("post_redirect_beats", (beats - b0) > 0, 1'b1);

      // Redirect in the same cycle a response arrives.
      rsp_en = 1'b0;
      repeat (3) step(1'b0, '0, 1'b0);
      rsp_en = 1'b1;
      step(1'b1, 32'h500, 1'b1);
      repeat (15) step(1'b0, '0, 1'b0);

      // Bus error on the word at 0x108, then a downstream stall.
      do_reset();
      for (int k = 0; k < 60 && pc_exp < 32'h110; k++) step(1'b0, '0, 1'b0);
      chk("err_beat_108", saw_err108, 1'b1);
      rdy_pct = 0;
      repeat (6) step(1'b0, '0, 1'b0);
      chk("stall_fill", last_in_flight, DEPTH);
      chk("stall_valid", last_valid, 1'b1);
      rdy_pct = 100;
      repeat (4) step(1'b0, '0, 1'b0);

      // Target with bit 1 set.
      step(1'b1, 32'h206, 1'b0);
      repeat (12) step(1'b0, '0, 1'b0);

      // Randomized traffic, back-pressure and redirects.
      for (int t = 0; t < 45; t++) begin
         rdy_pct     = $urandom_range(20, 100);
         rsp_pct     = $urandom_range(30, 100);
         req_rdy_pct = $urandom_range(30, 100);
         step(1'b1, 32'h1000 + 32'($urandom_range(0, 255)), 1'b0);
         if ($urandom_range(3) == 0) step(1'b1, 32'h1000 + 32'($urandom_range(0, 255)), 1'b0);
         repeat ($urandom_range(5, 50)) step(1'b0, '0, 1'b0);
      end
      rdy_pct = 100; rsp_pct = 100; req_rdy_pct = 100;
      repeat (10) step(1'b0, '0, 1'b0);
      chk("total_beats", beats > 100, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
